// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel/SRAM stage and the monitor pins.
// The generator drives through the master modport; consumers attach through slave.
interface vga_timing_gen_if;
  logic [11:0] char_count;
  logic [11:0] line_count;
  logic        blank;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
  logic        vblank;

  modport master (
    output char_count,
    output line_count,
    output blank,
    output hsync,
    output vsync,
    output line_start,
    output frame_start,
    output vblank
  );

  modport slave (
    input char_count,
    input line_count,
    input blank,
    input hsync,
    input vsync,
    input line_start,
    input frame_start,
    input vblank
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: char/line counters, blank/vblank, sync pins and line/frame strobes.
// Define SYNC_DELAY_EN to delay hsync/vsync by SYNC_DELAY cycles to match the pixel pipeline.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1024,
  parameter int unsigned H_FP       = 24,
  parameter int unsigned H_SYNC     = 136,
  parameter int unsigned H_BP       = 160,
  parameter int unsigned V_ACTIVE   = 768,
  parameter int unsigned V_FP       = 3,
  parameter int unsigned V_SYNC     = 6,
  parameter int unsigned V_BP       = 29,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic             char_clock,
  input  logic             reset,
  vga_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Inclusive upper bounds keep every compare inside 12 bits even when a total is 4096.
  localparam logic [11:0] HTotLast = 12'(H_TOTAL - 1);
  localparam logic [11:0] VTotLast = 12'(V_TOTAL - 1);
  localparam logic [11:0] HActLast = 12'(H_ACTIVE - 1);
  localparam logic [11:0] VActLast = 12'(V_ACTIVE - 1);
  localparam logic [11:0] HsFirst  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HsLast   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VsFirst  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VsLast   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > 4096) begin : g_chk_h_total
    $error("vga_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 4096) begin : g_chk_v_total
    $error("vga_timing_gen: V_TOTAL exceeds 4096");
  end
  if (SYNC_DELAY < 1) begin : g_chk_sync_delay
    $error("vga_timing_gen: SYNC_DELAY must be at least 1");
  end

  logic [11:0] char_q, char_d;
  logic [11:0] line_q, line_d;
  logic        blank_q, blank_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        vblank_q, vblank_d;

  // Outputs are decoded from the next-state counts so they line up with the registered counts.
  always_comb begin
    char_d = char_q + 12'd1;
    line_d = line_q;
    if (char_q == HTotLast) begin
      char_d = '0;
      if (line_q == VTotLast) begin
        line_d = '0;
      end else begin
        line_d = line_q + 12'd1;
      end
    end

    blank_d       = (char_d <= HActLast) && (line_d <= VActLast);
    vblank_d      = (line_d > VActLast);
    hsync_d       = ((char_d >= HsFirst) && (char_d <= HsLast)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d       = ((line_d >= VsFirst) && (line_d <= VsLast)) ? V_SYNC_POL : ~V_SYNC_POL;
    line_start_d  = (char_d == 12'd0);
    frame_start_d = (char_d == 12'd0) && (line_d == 12'd0);
  end

  always_ff @(posedge char_clock) begin
    if (reset) begin
      char_q        <= '0;
      line_q        <= '0;
      blank_q       <= 1'b0;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      char_q        <= char_d;
      line_q        <= line_d;
      blank_q       <= blank_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

`ifdef SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_pipe_q;
  logic [SYNC_DELAY-1:0] vs_pipe_q;

  always_ff @(posedge char_clock) begin
    if (reset) begin
      hs_pipe_q <= {SYNC_DELAY{~H_SYNC_POL}};
      vs_pipe_q <= {SYNC_DELAY{~V_SYNC_POL}};
    end else begin
      hs_pipe_q[0] <= hsync_q;
      vs_pipe_q[0] <= vsync_q;
      for (int i = 1; i < int'(SYNC_DELAY); i++) begin
        hs_pipe_q[i] <= hs_pipe_q[i-1];
        vs_pipe_q[i] <= vs_pipe_q[i-1];
      end
    end
  end

  assign vid.hsync = hs_pipe_q[SYNC_DELAY-1];
  assign vid.vsync = vs_pipe_q[SYNC_DELAY-1];
`else
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
`endif

  assign vid.char_count  = char_q;
  assign vid.line_count  = line_q;
  assign vid.blank       = blank_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.vblank      = vblank_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken 25x16 raster so whole frames stay short.
module tb_vga_timing_gen;

  localparam int unsigned HA = 16;
  localparam int unsigned HF = 2;
  localparam int unsigned HS = 4;
  localparam int unsigned HB = 3;
  localparam int unsigned HT = 25;
  localparam int unsigned VA = 10;
  localparam int unsigned VF = 1;
  localparam int unsigned VS = 2;
  localparam int unsigned VB = 3;
  localparam int unsigned VT = 16;
`ifdef SYNC_DELAY_EN
  localparam int unsigned SD = 2;
`else
  localparam int unsigned SD = 0;
`endif

  logic char_clock = 1'b0;
  logic reset      = 1'b1;

  vga_timing_gen_if vid_if ();

  vga_timing_gen #(
    .H_ACTIVE   (HA),
    .H_FP       (HF),
    .H_SYNC     (HS),
    .H_BP       (HB),
    .V_ACTIVE   (VA),
    .V_FP       (VF),
    .V_SYNC     (VS),
    .V_BP       (VB),
    .H_SYNC_POL (1'b0),
    .V_SYNC_POL (1'b0),
    .SYNC_DELAY (2)
  ) u_dut (
    .char_clock (char_clock),
    .reset      (reset),
    .vid        (vid_if.master)
  );

  always #5 char_clock = ~char_clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance (sampling on negedges) until the given position is shown, within two frames.
  task automatic wait_at(input int unsigned cx, input int unsigned ly, input string tag);
    int unsigned n = 0;
    while (!(vid_if.char_count == 12'(cx) && vid_if.line_count == 12'(ly)) && n < 2*HT*VT) begin
      @(negedge char_clock);
      n++;
    end
    check({tag, "_reached"}, int'(n < 2*HT*VT), 1);
  endtask

  int unsigned blank_cnt, hs_cnt, hs_first, ls_cnt;
  int unsigned vs_cnt, vs_first_c, vs_first_l, vb_cnt, bad_blank, fs_cnt;
  bit          seen;

  initial begin
    reset = 1'b1;
    repeat (5) @(negedge char_clock);
    check("rst_char",  vid_if.char_count, 0);
    check("rst_line",  vid_if.line_count, 0);
    check("rst_blank", vid_if.blank, 0);
    check("rst_hsync", vid_if.hsync, 1);
    check("rst_vsync", vid_if.vsync, 1);
    check("rst_ls",    vid_if.line_start, 0);
    check("rst_fs",    vid_if.frame_start, 0);
    check("rst_vblank", vid_if.vblank, 0);

    reset = 1'b0;
    @(negedge char_clock);
    check("rel_char",  vid_if.char_count, 1);
    check("rel_line",  vid_if.line_count, 0);
    check("rel_blank", vid_if.blank, 1);
    check("rel_ls",    vid_if.line_start, 0);
    check("rel_fs",    vid_if.frame_start, 0);

    // One full line starting at char 0 of line 1.
    wait_at(0, 1, "line1");
    blank_cnt = 0; hs_cnt = 0; hs_first = 0; ls_cnt = 0; seen = 0;
    for (int i = 0; i < int'(HT); i++) begin
      blank_cnt += int'(vid_if.blank);
      ls_cnt    += int'(vid_if.line_start);
      if (!vid_if.hsync) begin
        hs_cnt++;
        if (!seen) begin
          hs_first = vid_if.char_count;
          seen     = 1;
        end
      end
      @(negedge char_clock);
    end
    check("line_blank_cnt", blank_cnt, 16);
    check("line_hs_cnt",    hs_cnt, 4);
    check("line_hs_first",  hs_first, 18 + SD);
    check("line_ls_cnt",    ls_cnt, 1);
    check("line_ls_period", vid_if.line_start, 1);
    check("line2_char",     vid_if.char_count, 0);
    check("line2_line",     vid_if.line_count, 2);

    // One full frame starting at (0,0).
    wait_at(0, 0, "frame0");
    check("frame0_fs", vid_if.frame_start, 1);
    blank_cnt = 0; vs_cnt = 0; vs_first_c = 0; vs_first_l = 0; vb_cnt = 0;
    bad_blank = 0; fs_cnt = 0; seen = 0;
    for (int i = 0; i < int'(HT*VT); i++) begin
      blank_cnt += int'(vid_if.blank);
      vb_cnt    += int'(vid_if.vblank);
      fs_cnt    += int'(vid_if.frame_start);
      if (vid_if.blank && vid_if.line_count >= 12'(VA)) bad_blank++;
      if (!vid_if.vsync) begin
        vs_cnt++;
        if (!seen) begin
          vs_first_c = vid_if.char_count;
          vs_first_l = vid_if.line_count;
          seen       = 1;
        end
      end
      @(negedge char_clock);
    end
    check("frm_blank_cnt", blank_cnt, 160);
    check("frm_vblank_cnt", vb_cnt, 150);
    check("frm_bad_blank", bad_blank, 0);
    check("frm_fs_cnt",    fs_cnt, 1);
    check("frm_vs_cnt",    vs_cnt, 50);
    check("frm_vs_line",   vs_first_l, 11);
    check("frm_vs_char",   vs_first_c, SD);
    check("frm_fs_period", vid_if.frame_start, 1);

    // Wrap corner.
    wait_at(HT-1, VT-1, "corner");
    check("corner_vblank", vid_if.vblank, 1);
    check("corner_blank",  vid_if.blank, 0);
    @(negedge char_clock);
    check("wrap_char",   vid_if.char_count, 0);
    check("wrap_line",   vid_if.line_count, 0);
    check("wrap_ls",     vid_if.line_start, 1);
    check("wrap_fs",     vid_if.frame_start, 1);
    check("wrap_blank",  vid_if.blank, 1);
    check("wrap_vblank", vid_if.vblank, 0);

    // Single-cycle reset mid-line while hsync is active.
    wait_at(20, 7, "midrst");
    check("mid_hsync", vid_if.hsync, 0);
    reset = 1'b1;
    @(negedge char_clock);
    check("mid_rst_char",  vid_if.char_count, 0);
    check("mid_rst_line",  vid_if.line_count, 0);
    check("mid_rst_blank", vid_if.blank, 0);
    check("mid_rst_hsync", vid_if.hsync, 1);
    check("mid_rst_vsync", vid_if.vsync, 1);
    reset = 1'b0;
    @(negedge char_clock);
    check("mid_rel_char",  vid_if.char_count, 1);
    check("mid_rel_line",  vid_if.line_count, 0);
    check("mid_rel_blank", vid_if.blank, 1);
    check("mid_rel_hsync", vid_if.hsync, 1);
    check("mid_rel_fs",    vid_if.frame_start, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
